// File: rtl/song_reader_pkg.sv
// -----------------------------------------------------------------------------
// song_reader_pkg
// Shared definitions for the song reader: field widths, FSM state encodings,
// the end-of-song terminator value and the song data table that backs the
// song ROM.
//
// Contents:
//   NOTE_BITS / DURATION_BITS / SONG_BITS / INDEX_BITS  field widths
//   ADDR_BITS / WORD_BITS                               ROM geometry
//   state_t + ST_*                                      FSM state encodings
//   DURATION_END                                        terminator duration
//   song_word()                                         song data table
// -----------------------------------------------------------------------------
package song_reader_pkg;

    localparam int NOTE_BITS     = 6;
    localparam int DURATION_BITS = 6;
    localparam int SONG_BITS     = 2;
    localparam int INDEX_BITS    = 5;

    localparam int ADDR_BITS = SONG_BITS + INDEX_BITS;
    localparam int WORD_BITS = NOTE_BITS + DURATION_BITS;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD   = 3'd1;
    localparam state_t ST_LOAD = 3'd2;
    localparam state_t ST_WAIT = 3'd3;
    localparam state_t ST_END  = 3'd4;

    // A ROM entry with this duration marks the end of a song.
    localparam logic [DURATION_BITS-1:0] DURATION_END = '0;

    // Song data. Each word is {note, duration}; address is {song, index}.
    // Slots not listed read as zero, i.e. a terminator.
    //   song 0: two notes, then a terminator whose note field is non-zero
    //   song 1: 32 entries, note = index (slot 0 is a rest), duration = index+1
    //   song 2: one note, one rest, then end
    //   song 3: one note, then end
    function automatic logic [WORD_BITS-1:0] song_word(input logic [ADDR_BITS-1:0] addr);
        logic [SONG_BITS-1:0]     sel;
        logic [INDEX_BITS-1:0]    idx;
        logic [NOTE_BITS-1:0]     n;
        logic [DURATION_BITS-1:0] d;
        sel = addr[ADDR_BITS-1:INDEX_BITS];
        idx = addr[INDEX_BITS-1:0];
        n   = '0;
        d   = '0;
        case (sel)
            2'd0: begin
                case (idx)
                    5'd0:    begin n = 6'd20; d = 6'd12; end
                    5'd1:    begin n = 6'd33; d = 6'd5;  end
                    5'd2:    begin n = 6'd7;  d = 6'd0;  end
                    default: begin n = 6'd0;  d = 6'd0;  end
                endcase
            end
            2'd1: begin
                n = {1'b0, idx};
                d = {1'b0, idx} + 6'd1;
            end
            2'd2: begin
                case (idx)
                    5'd0:    begin n = 6'd45; d = 6'd24; end
                    5'd1:    begin n = 6'd0;  d = 6'd6;  end
                    default: begin n = 6'd0;  d = 6'd0;  end
                endcase
            end
            default: begin
                case (idx)
                    5'd0:    begin n = 6'd10; d = 6'd3; end
                    default: begin n = 6'd0;  d = 6'd0; end
                endcase
            end
        endcase
        return {n, d};
    endfunction

endpackage

// File: rtl/dffre.sv
// -----------------------------------------------------------------------------
// dffre
// Generic D flip-flop with synchronous active-high reset (to zero) and
// load enable.
//
// Ports:
//   clk  in   clock
//   r    in   synchronous reset, active-high, clears q
//   en   in   load enable
//   d    in   WIDTH  next value
//   q    out  WIDTH  registered value
// -----------------------------------------------------------------------------
module dffre #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (r) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/song_rom.sv
// -----------------------------------------------------------------------------
// song_rom
// Synchronous song ROM, 128 words of {note, duration}. Data for an address
// presented in one cycle appears on dout in the next cycle.
//
// Ports:
//   clk   in   clock
//   addr  in   7   {song, index}
//   dout  out  12  {note, duration}, registered
// -----------------------------------------------------------------------------
module song_rom
    import song_reader_pkg::*;
(
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    output logic [WORD_BITS-1:0] dout
);

    always_ff @(posedge clk) begin
        dout <= song_word(addr);
    end

endmodule

// File: rtl/song_reader.sv
// -----------------------------------------------------------------------------
// song_reader
// Walks the song ROM one entry at a time, hands each note/duration to the
// note player with a one-cycle new_note pulse, then waits for note_done
// before fetching the next entry. End of song (terminator entry or the last
// slot completing) is flagged with a one-cycle song_done pulse.
//
// Ports:
//   clk        in   1              system clock
//   reset      in   1              synchronous, active-high
//   play       in   1              high: advance; low: hold before next fetch
//   song       in   SONG_BITS      selected song
//   note_done  in   1              note player finished the current note
//   note       out  NOTE_BITS      note to load, registered
//   duration   out  DURATION_BITS  duration to load, registered
//   new_note   out  1              one-cycle load pulse
//   song_done  out  1              one-cycle end-of-song pulse
// -----------------------------------------------------------------------------
module song_reader
    import song_reader_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     play,
    input  logic [SONG_BITS-1:0]     song,
    input  logic                     note_done,
    output logic [NOTE_BITS-1:0]     note,
    output logic [DURATION_BITS-1:0] duration,
    output logic                     new_note,
    output logic                     song_done
);

    localparam logic [INDEX_BITS-1:0] INDEX_LAST = '1;
    localparam logic [INDEX_BITS-1:0] INDEX_ONE  = {{(INDEX_BITS-1){1'b0}}, 1'b1};

    state_t                   state_q,     state_d;
    logic [INDEX_BITS-1:0]    index_q,     index_d;
    logic [SONG_BITS-1:0]     song_q,      song_d;
    logic [NOTE_BITS-1:0]     note_q,      note_d;
    logic [DURATION_BITS-1:0] duration_q,  duration_d;
    logic                     new_note_q,  new_note_d;
    logic                     song_done_q, song_done_d;
    logic                     load_en;

    logic [WORD_BITS-1:0]     rom_dout;
    logic [NOTE_BITS-1:0]     rom_note;
    logic [DURATION_BITS-1:0] rom_duration;
    logic                     song_change;

    // Address only moves on a song change or an index increment, both of
    // which return to IDLE, so the ROM has a full cycle to settle before RD.
    song_rom u_song_rom (
        .clk  (clk),
        .addr ({song_q, index_q}),
        .dout (rom_dout)
    );

    assign rom_note     = rom_dout[WORD_BITS-1:DURATION_BITS];
    assign rom_duration = rom_dout[DURATION_BITS-1:0];
    assign song_change  = (song != song_q);

    assign note_d     = rom_note;
    assign duration_d = rom_duration;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        song_d      = song_q;
        new_note_d  = 1'b0;
        song_done_d = 1'b0;
        load_en     = 1'b0;

        if (song_change) begin
            // Restart the new song; any pulse that would have been launched
            // this cycle is dropped.
            song_d  = song;
            index_d = '0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (play) begin
                        state_d = ST_RD;
                    end
                end
                ST_RD: begin
                    // ROM data is valid now; decide here so that note/duration
                    // and the matching pulse all appear together in LOAD.
                    state_d = ST_LOAD;
                    if (rom_duration != DURATION_END) begin
                        load_en    = 1'b1;
                        new_note_d = 1'b1;
                    end else begin
                        song_done_d = 1'b1;
                    end
                end
                ST_LOAD: begin
                    // new_note_q is high in LOAD exactly when the entry was a note.
                    state_d = new_note_q ? ST_WAIT : ST_END;
                end
                ST_WAIT: begin
                    if (note_done) begin
                        if (index_q == INDEX_LAST) begin
                            song_done_d = 1'b1;
                            state_d     = ST_END;
                        end else begin
                            index_d = index_q + INDEX_ONE;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_END: begin
                    state_d = ST_END;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    dffre #(.WIDTH(3)) u_state_q (
        .clk (clk), .r (reset), .en (1'b1), .d (state_d), .q (state_q)
    );

    dffre #(.WIDTH(INDEX_BITS)) u_index_q (
        .clk (clk), .r (reset), .en (1'b1), .d (index_d), .q (index_q)
    );

    dffre #(.WIDTH(SONG_BITS)) u_song_q (
        .clk (clk), .r (reset), .en (1'b1), .d (song_d), .q (song_q)
    );

    dffre #(.WIDTH(NOTE_BITS)) u_note_q (
        .clk (clk), .r (reset), .en (load_en), .d (note_d), .q (note_q)
    );

    dffre #(.WIDTH(DURATION_BITS)) u_duration_q (
        .clk (clk), .r (reset), .en (load_en), .d (duration_d), .q (duration_q)
    );

    dffre #(.WIDTH(1)) u_new_note_q (
        .clk (clk), .r (reset), .en (1'b1), .d (new_note_d), .q (new_note_q)
    );

    dffre #(.WIDTH(1)) u_song_done_q (
        .clk (clk), .r (reset), .en (1'b1), .d (song_done_d), .q (song_done_q)
    );

    assign note      = note_q;
    assign duration  = duration_q;
    assign new_note  = new_note_q;
    assign song_done = song_done_q;

endmodule

// File: tb/tb_song_reader.sv
// -----------------------------------------------------------------------------
// tb_song_reader
// Directed testbench for song_reader. Expected values are hand-derived from
// the song table contents and the cycle timing of the reader.
// -----------------------------------------------------------------------------
module tb_song_reader;

    logic       clk;
    logic       reset;
    logic       play;
    logic [1:0] song;
    logic       note_done;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       song_done;

    int n_checks;
    int n_errors;

    song_reader dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .note_done (note_done),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .song_done (song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nn;
        int sd;
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        play      = 1'b0;
        song      = 2'd0;
        note_done = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_note", note, 0);
        chk("rst_dur", duration, 0);
        chk("rst_new_note", new_note, 0);
        chk("rst_song_done", song_done, 0);

        // First note: play high from cycle 0, new_note in cycle 2
        reset = 1'b0;
        play  = 1'b1;
        chk("c0_new_note", new_note, 0);
        tick();
        chk("c1_new_note", new_note, 0);
        tick();
        chk("c2_new_note", new_note, 1);
        chk("c2_note", note, 20);
        chk("c2_dur", duration, 12);
        nn = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            nn += int'(new_note);
        end
        chk("wait_quiet", nn, 0);
        chk("wait_note_hold", note, 20);

        // note_done at index 0 -> ROM[1] three cycles later
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
        chk("nd_t1", new_note, 0);
        tick();
        chk("nd_t2", new_note, 0);
        tick();
        chk("nd_t3_new_note", new_note, 1);
        chk("nd_t3_note", note, 33);
        chk("nd_t3_dur", duration, 5);

        // Pause: restart, drop play in WAIT at index 0, park in IDLE
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("p_load", new_note, 1);
        tick();
        play      = 1'b0;
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
        nn = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            nn += int'(new_note);
        end
        chk("p_parked", nn, 0);
        play = 1'b1;
        tick();
        chk("p_rd", new_note, 0);
        tick();
        chk("p_new_note", new_note, 1);
        chk("p_note", note, 33);
        chk("p_dur", duration, 5);

        // Terminator at ROM[2]: song_done in the LOAD cycle, outputs kept
        tick();
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
        tick();
        tick();
        chk("term_song_done", song_done, 1);
        chk("term_new_note", new_note, 0);
        chk("term_note", note, 33);
        chk("term_dur", duration, 5);
        tick();
        chk("term_pulse_end", song_done, 0);
        nn = 0;
        sd = 0;
        for (int i = 0; i < 100; i++) begin
            note_done = ((i % 7) == 3);
            tick();
            nn += int'(new_note);
            sd += int'(song_done);
        end
        note_done = 1'b0;
        chk("end_new_note", nn, 0);
        chk("end_song_done", sd, 0);
        chk("end_note", note, 33);

        // Song 1: 32 notes, then song_done after the 32nd note_done
        song = 2'd1;
        tick();
        chk("s1_t1", new_note, 0);
        tick();
        tick();
        chk("s1_first", new_note, 1);
        chk("s1_first_note", note, 0);
        chk("s1_first_dur", duration, 1);
        for (int i = 0; i < 32; i++) begin
            tick();
            note_done = 1'b1;
            tick();
            note_done = 1'b0;
            if (i < 31) begin
                chk("s1_gap_sd", song_done, 0);
                tick();
                chk("s1_gap_nn", new_note, 0);
                tick();
                chk("s1_new_note", new_note, 1);
                chk("s1_note", note, i + 1);
                chk("s1_dur", duration, i + 2);
            end else begin
                chk("s1_last_song_done", song_done, 1);
                chk("s1_last_new_note", new_note, 0);
                tick();
                chk("s1_last_pulse_end", song_done, 0);
            end
        end

        // Back to song 0, then switch to song 2 mid-WAIT with note_done
        song = 2'd0;
        tick();
        tick();
        tick();
        chk("s0_new_note", new_note, 1);
        chk("s0_note", note, 20);
        tick();
        song      = 2'd2;
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
        chk("sw_song_done", song_done, 0);
        chk("sw_new_note", new_note, 0);
        tick();
        chk("sw_t2", new_note, 0);
        tick();
        chk("sw_new_note_t3", new_note, 1);
        chk("sw_note", note, 45);
        chk("sw_dur", duration, 24);
        // Next entry must be ROM[65] (index restarted, not incremented twice)
        tick();
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
        tick();
        tick();
        chk("s2_rest_new_note", new_note, 1);
        chk("s2_rest_note", note, 0);
        chk("s2_rest_dur", duration, 6);

        // Reset mid-song clears the output registers
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_note", note, 0);
        chk("rst2_dur", duration, 0);
        chk("rst2_new_note", new_note, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
